// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - opcode, alu_op and control-bundle definitions shared by the decode stage
package id_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       branch;
      logic       mem_write;
      logic       mem_read;
      logic       alu_src;
      logic       reg_dst;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

   function automatic ctrl_t decode_op(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            c.alu_op    = ALU_FUNCT;
         end
         OP_LW: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.mem_read   = 1'b1;
            c.alu_src    = 1'b1;
            c.alu_op     = ALU_ADD;
         end
         OP_SW: begin
            c.mem_write = 1'b1;
            c.alu_src   = 1'b1;
            c.alu_op    = ALU_ADD;
         end
         OP_BEQ: begin
            c.branch = 1'b1;
            c.alu_op = ALU_SUB;
         end
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

   // Instructions whose rt field is a source operand rather than a destination
   function automatic logic uses_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// rtl/reg_file_bypass.sv - 32-entry two-read one-write register file with write-to-read bypass
module reg_file_bypass #(
   parameter int DATA_W   = 32,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [4:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [4:0]        raddr_a,
   input  logic [4:0]        raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs [32];
   logic              wr_en;

   assign wr_en = we && ((ZERO_REG == 0) || (waddr != 5'd0));

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[waddr] <= wdata;
      end
   end

   // A writeback landing this cycle wins over the stored value
   always_comb begin
      rdata_a = regs[raddr_a];
      if ((ZERO_REG != 0) && (raddr_a == 5'd0)) rdata_a = '0;
      else if (wr_en && (waddr == raddr_a))     rdata_a = wdata;
   end

   always_comb begin
      rdata_b = regs[raddr_b];
      if ((ZERO_REG != 0) && (raddr_b == 5'd0)) rdata_b = '0;
      else if (wr_en && (waddr == raddr_b))     rdata_b = wdata;
   end

endmodule

// File: rtl/id_decode_pipe.sv
// rtl/id_decode_pipe.sv - MIPS decode stage: control decode, load-use hazard and ID/EX register
module id_decode_pipe
   import id_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [31:0]       if_instr,
   input  logic              flush,
   input  logic              wb_reg_write,
   input  logic [4:0]        wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   output logic              id_stall,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_to_reg,
   output logic              ex_branch,
   output logic              ex_mem_write,
   output logic              ex_mem_read,
   output logic              ex_alu_src,
   output logic              ex_reg_dst,
   output logic [1:0]        ex_alu_op,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic              ex_illegal
);

   logic [5:0]        opcode;
   logic [4:0]        rs, rt, rd;
   logic [DATA_W-1:0] rs_val, rt_val, imm_ext;
   ctrl_t             dec_ctrl, ctrl_q;
   logic              hazard, load;

   assign opcode  = if_instr[31:26];
   assign rs      = if_instr[25:21];
   assign rt      = if_instr[20:16];
   assign rd      = if_instr[15:11];
   assign imm_ext = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};
   assign dec_ctrl = decode_op(opcode);

   reg_file_bypass #(
      .DATA_W   (DATA_W),
      .ZERO_REG (ZERO_REG)
   ) u_rf (
      .clk     (clk),
      .reset   (reset),
      .we      (wb_reg_write),
      .waddr   (wb_reg),
      .wdata   (wb_data),
      .raddr_a (rs),
      .raddr_b (rt),
      .rdata_a (rs_val),
      .rdata_b (rt_val)
   );

   // A load in EX cannot forward in time for a consumer sitting in decode
   assign hazard = if_valid && ex_valid && ctrl_q.mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == rs) || (uses_rt(opcode) && (ex_rt == rt)));

   assign id_stall = hazard && !flush && reset;
   assign load     = if_valid && !flush && !hazard;

   always_ff @(posedge clk) begin
      if (!reset || !load) begin
         ex_valid   <= 1'b0;
         ctrl_q     <= '0;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
      end else begin
         ex_valid   <= 1'b1;
         ctrl_q     <= dec_ctrl;
         ex_rs_data <= rs_val;
         ex_rt_data <= rt_val;
         ex_imm     <= imm_ext;
         ex_rs      <= rs;
         ex_rt      <= rt;
         ex_rd      <= rd;
      end
   end

   assign ex_reg_write  = ctrl_q.reg_write;
   assign ex_mem_to_reg = ctrl_q.mem_to_reg;
   assign ex_branch     = ctrl_q.branch;
   assign ex_mem_write  = ctrl_q.mem_write;
   assign ex_mem_read   = ctrl_q.mem_read;
   assign ex_alu_src    = ctrl_q.alu_src;
   assign ex_reg_dst    = ctrl_q.reg_dst;
   assign ex_alu_op     = ctrl_q.alu_op;
   assign ex_illegal    = ctrl_q.illegal;

endmodule

// File: doc/id_decode_pipe.md
ID_DECODE_PIPE -- requirements
Module: id_decode_pipe

Interface
REQ-001 Parameter DATA_W, default 32, register and data width; immediate sign-extended from 16 to DATA_W bits.
REQ-002 Parameter ZERO_REG, default 1, when 1 register 0 reads as zero and ignores writes.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 if_valid  input  1  instruction on if_instr is valid.
REQ-006 if_instr  input  32  MIPS-encoded instruction.
REQ-007 flush  input  1  kill the instruction currently in decode (taken branch).
REQ-008 wb_reg_write, wb_reg, wb_data  input  1/5/DATA_W  writeback port.
REQ-009 id_stall  output  1  combinational; IF shall hold if_instr when high.
REQ-010 ex_valid  output  1  registered; ID/EX slot holds a live instruction.
REQ-011 ex_reg_write, ex_mem_to_reg, ex_branch, ex_mem_write, ex_mem_read, ex_alu_src, ex_reg_dst  output  1 each  registered control.
REQ-012 ex_alu_op  output  2  registered ALU class.
REQ-013 ex_rs_data, ex_rt_data, ex_imm  output  DATA_W each  registered operands.
REQ-014 ex_rs, ex_rt, ex_rd  output  5 each  registered register numbers.
REQ-015 ex_illegal  output  1  registered; decoded opcode unsupported.

Function
REQ-016 Decode: R-type 000000 -> reg_write, reg_dst, alu_op 10; lw 100011 -> reg_write, mem_to_reg, mem_read, alu_src, alu_op 00; sw 101011 -> mem_write, alu_src, alu_op 00; beq 000100 -> branch, alu_op 01.
REQ-017 Any other opcode: all control bits 0, ex_illegal 1, ex_valid still 1.
REQ-018 Latency: instruction accepted at edge N appears on ex_* after edge N, i.e. one cycle.
REQ-019 Register file: write at edge when wb_reg_write=1 (and wb_reg!=0 if ZERO_REG=1).
REQ-020 Read bypass: same-cycle write to a read address returns wb_data, not stale content.
REQ-021 Load-use hazard: ex_valid & ex_mem_read & ex_rt!=0 & (ex_rt==rs, or ex_rt==rt for R-type/sw/beq) with if_valid -> id_stall=1.
REQ-022 On stall: ID/EX loads a bubble (ex_valid=0, all control 0); instruction re-decoded next cycle.
REQ-023 Stall lasts exactly one cycle per load-use pair.
REQ-024 flush=1: ID/EX loads a bubble, id_stall forced 0, regardless of hazard.
REQ-025 if_valid=0: ID/EX loads a bubble.
REQ-026 Priority: reset > flush > stall > normal load.
REQ-027 Register-file write proceeds during stall and flush.

Reset
REQ-028 reset=0 at an edge: ex_valid, all ex_* control, ex_illegal, operands, immediate and register numbers cleared to 0.
REQ-029 reset=0 clears all register-file entries to 0; concurrent writeback ignored.
REQ-030 id_stall is 0 during and on the first cycle after reset (ex_valid=0).

Structure
REQ-031 Shared package id_pkg holds opcode constants, alu_op encodings and the control-bundle typedef.
REQ-032 Register file with bypass is sub-module reg_file_bypass, parametrised by DATA_W and ZERO_REG.
REQ-033 Decode, hazard detection and ID/EX register live in id_decode_pipe.

Verification
REQ-034 Reset, then add $3,$1,$2 with $1=5,$2=7 written earlier -> next cycle ex_valid=1, alu_op 10, reg_dst 1, rs_data 5, rt_data 7, rd 3.
REQ-035 lw $4,-4($1) then add $5,$4,$2 -> id_stall=1 one cycle, one bubble, then add issues with rs=4.
REQ-036 WB writes $6=0xDEADBEEF same cycle as decode of sw $6,0($0) -> ex_rt_data 0xDEADBEEF, ex_imm 0.
REQ-037 Write $0=99 then read $0 (ZERO_REG=1) -> ex_rs_data 0.
REQ-038 Flush asserted during load-use stall -> id_stall 0, bubble, next instruction accepted following cycle.
REQ-039 Opcode 111111 -> ex_valid 1, ex_illegal 1, all control 0; reset mid-stream -> all outputs 0 next cycle.
